instr_fetch_unit: RTL

- Fetch stage of the 16-bit RISC pipeline; sits directly downstream of the control unit's fetch-enable output.
- Each fetch-enable pulse starts one read of instruction memory through a req/ack handshake that tolerates wait states.
- Latches the returned instruction and its address for the decode stage, advances the PC, and accepts branch/jump redirects.
- A bounded wait timer flags memories that never acknowledge.

---
 rtl/instr_fetch_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch stage of the 16-bit RISC pipeline. Each fetch-enable pulse issues one
//   instruction-memory read over a req/ack handshake that tolerates wait states.
//   The returned word and its address are latched for decode and the PC
//   advances. Branch/jump redirects load the PC. If a redirect lands while a
//   fetch is outstanding, the in-flight word is squashed. A bounded wait timer
//   aborts fetches that are never acknowledged.
//
// Ports
//   I_clk          clock, rising edge
//   I_reset_n      asynchronous active-low reset
//   I_enfetch      fetch-enable pulse from the control unit
//   I_pc_load      redirect strobe (branch/jump taken)
//   I_pc_target    redirect address
//   O_imem_req     instruction memory request
//   O_imem_addr    instruction memory address
//   I_imem_ack     memory acknowledge, I_imem_rdata valid in the same cycle
//   I_imem_rdata   memory read data
//   O_instr        fetched instruction
//   O_instr_pc     address O_instr was fetched from
//   O_instr_valid  O_instr holds a valid fetched word
//   O_pc           next-to-fetch PC
//   O_busy         fetch outstanding
//   O_fetch_err    last fetch timed out
//
// State | meaning
// IDLE  | no fetch outstanding, waiting for I_enfetch
// WAIT  | request issued, waiting for ack or timeout
module instr_fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15
) (
    input  logic              I_clk,
    input  logic              I_reset_n,
    input  logic              I_enfetch,
    input  logic              I_pc_load,
    input  logic [ADDR_W-1:0] I_pc_target,
    output logic              O_imem_req,
    output logic [ADDR_W-1:0] O_imem_addr,
    input  logic              I_imem_ack,
    input  logic [DATA_W-1:0] I_imem_rdata,
    output logic [DATA_W-1:0] O_instr,
    output logic [ADDR_W-1:0] O_instr_pc,
    output logic              O_instr_valid,
    output logic [ADDR_W-1:0] O_pc,
    output logic              O_busy,
    output logic              O_fetch_err
);

    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

    // The wait timer counts down from TIMEOUT-1. A count of zero while no ack
    // is present is the last permitted WAIT cycle.
    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              valid_q, valid_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              squash_q, squash_d;
    logic [7:0]        cnt_q, cnt_d;

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            squash_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            squash_q   <= squash_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;
        squash_d   = squash_q;
        cnt_d      = cnt_q;

        case (state_q)
            IDLE: begin
                if (I_pc_load) begin
                    pc_d = I_pc_target;
                end
                if (I_enfetch) begin
                    req_d    = 1'b1;
                    addr_d   = I_pc_load ? I_pc_target : pc_q;
                    valid_d  = 1'b0;
                    err_d    = 1'b0;
                    squash_d = 1'b0;
                    cnt_d    = TMO_LOAD;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                if (I_imem_ack) begin
                    req_d    = 1'b0;
                    squash_d = 1'b0;
                    state_d  = IDLE;
                    // A redirect in the ack cycle wins over the returning word.
                    if (I_pc_load) begin
                        pc_d = I_pc_target;
                    end else if (!squash_q) begin
                        instr_d    = I_imem_rdata;
                        instr_pc_d = addr_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 1'b1;
                    end
                end else begin
                    if (I_pc_load) begin
                        pc_d     = I_pc_target;
                        squash_d = 1'b1;
                    end
                    if (cnt_q == 8'd0) begin
                        // Nothing remains in flight after an abort, so any
                        // pending squash is dropped.
                        req_d    = 1'b0;
                        err_d    = 1'b1;
                        squash_d = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == WAIT);
    end

    assign O_imem_req    = req_q;
    assign O_imem_addr   = addr_q;
    assign O_instr       = instr_q;
    assign O_instr_pc    = instr_pc_q;
    assign O_instr_valid = valid_q;
    assign O_pc          = pc_q;
    assign O_busy        = busy_q;
    assign O_fetch_err   = err_q;

endmodule
